lobster_dbus_arbiter: RTL and testbench

Single-port data-bus arbiter and sequencer for the Lobster128 CPU. Shares the one SRAM port (ce/we/address/data/rdy) between the three bus users: instruction fetch, data load and data store. It runs one transaction at a time, applies fixed priority with a fetch anti-starvation override, enforces a ready timeout, and returns read data with a requester tag. The executor and fetch logic sit on the requester side; the SRAM sits on the memory side.

---
 rtl/lobster_pkg.sv | 17 +
 rtl/lobster_dbus_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_lobster_dbus_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/lobster_pkg.sv
// Shared Lobster128 bus types: requester tags and
// the data-bus arbiter state encoding.
package lobster_pkg;

    typedef enum logic [1:0] {
        DBUS_NOP   = 2'b00,
        DBUS_FETCH = 2'b01,
        DBUS_LOAD  = 2'b10,
        DBUS_STORE = 2'b11
    } dbus_id_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

endpackage

// File: rtl/lobster_dbus_arbiter.sv
// Single-port SRAM arbiter for fetch/load/store with
// fetch anti-starvation and a ready timeout.
module lobster_dbus_arbiter
    import lobster_pkg::*;
#(
    parameter int ADDR_WIDTH   = 36,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    input  logic                  load_req,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    output logic                  load_gnt,
    input  logic                  store_req,
    input  logic [ADDR_WIDTH-1:0] store_addr,
    input  logic [63:0]           store_data,
    output logic                  store_gnt,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_id,
    output logic [63:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr_wr,
    output logic [63:0]           mem_wdata,
    input  logic [63:0]           mem_rdata,
    input  logic                  mem_rdy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [15:0]   TO_LAST    = 16'(TIMEOUT - 1);

    arb_state_t            state_q, state_d;
    dbus_id_t              tag_q, tag_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic [15:0]           to_q, to_d;
    logic                  fgnt_q, fgnt_d;
    logic                  lgnt_q, lgnt_d;
    logic                  sgnt_q, sgnt_d;
    logic                  rv_q, rv_d;
    dbus_id_t              rid_q, rid_d;
    logic [63:0]           rdata_q, rdata_d;
    logic                  rerr_q, rerr_d;
    logic                  ce_q, ce_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] ard_q, ard_d;
    logic [ADDR_WIDTH-1:0] awr_q, awr_d;
    logic [63:0]           wdat_q, wdat_d;
    dbus_id_t              win;

    // Starved fetch overrides the normal store > load > fetch order.
    function automatic dbus_id_t pick(
        input logic f,
        input logic l,
        input logic s,
        input logic starved
    );
        if (f && starved) return DBUS_FETCH;
        if (s)            return DBUS_STORE;
        if (l)            return DBUS_LOAD;
        if (f)            return DBUS_FETCH;
        return DBUS_NOP;
    endfunction

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] c);
        return (c == STARVE_MAX) ? c : c + 1'b1;
    endfunction

    assign win = pick(fetch_req, load_req, store_req,
                      starve_q == STARVE_MAX);

    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        starve_d = starve_q;
        to_d     = to_q;
        fgnt_d   = 1'b0;
        lgnt_d   = 1'b0;
        sgnt_d   = 1'b0;
        rv_d     = 1'b0;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        rerr_d   = 1'b0;
        ce_d     = ce_q;
        we_d     = we_q;
        ard_d    = ard_q;
        awr_d    = awr_q;
        wdat_d   = wdat_q;
        unique case (state_q)
            IDLE: begin
                if (!fetch_req) starve_d = '0;
                case (win)
                    DBUS_STORE: begin
                        awr_d  = store_addr;
                        wdat_d = store_data;
                        we_d   = 1'b1;
                        sgnt_d = 1'b1;
                        if (fetch_req) starve_d = sat_inc(starve_q);
                    end
                    DBUS_LOAD: begin
                        ard_d  = load_addr;
                        we_d   = 1'b0;
                        lgnt_d = 1'b1;
                        if (fetch_req) starve_d = sat_inc(starve_q);
                    end
                    DBUS_FETCH: begin
                        ard_d    = fetch_addr;
                        we_d     = 1'b0;
                        fgnt_d   = 1'b1;
                        starve_d = '0;
                    end
                    default: ;
                endcase
                if (win != DBUS_NOP) begin
                    ce_d    = 1'b1;
                    tag_d   = win;
                    to_d    = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_rdy) begin
                    ce_d    = 1'b0;
                    we_d    = 1'b0;
                    rv_d    = 1'b1;
                    rid_d   = tag_q;
                    rdata_d = (tag_q == DBUS_STORE) ? 64'h0 : mem_rdata;
                    state_d = IDLE;
                end else if (to_q == TO_LAST) begin
                    ce_d    = 1'b0;
                    we_d    = 1'b0;
                    rv_d    = 1'b1;
                    rerr_d  = 1'b1;
                    rid_d   = tag_q;
                    rdata_d = 64'h0;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            tag_q    <= DBUS_NOP;
            starve_q <= '0;
            to_q     <= '0;
            fgnt_q   <= 1'b0;
            lgnt_q   <= 1'b0;
            sgnt_q   <= 1'b0;
            rv_q     <= 1'b0;
            rid_q    <= DBUS_NOP;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            ce_q     <= 1'b0;
            we_q     <= 1'b0;
            ard_q    <= '0;
            awr_q    <= '0;
            wdat_q   <= '0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            starve_q <= starve_d;
            to_q     <= to_d;
            fgnt_q   <= fgnt_d;
            lgnt_q   <= lgnt_d;
            sgnt_q   <= sgnt_d;
            rv_q     <= rv_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            ce_q     <= ce_d;
            we_q     <= we_d;
            ard_q    <= ard_d;
            awr_q    <= awr_d;
            wdat_q   <= wdat_d;
        end
    end

    assign fetch_gnt   = fgnt_q;
    assign load_gnt    = lgnt_q;
    assign store_gnt   = sgnt_q;
    assign rsp_valid   = rv_q;
    assign rsp_id      = rid_q;
    assign rsp_data    = rdata_q;
    assign rsp_err     = rerr_q;
    assign busy        = (state_q != IDLE);
    assign mem_ce      = ce_q;
    assign mem_we      = we_q;
    assign mem_addr_rd = ard_q;
    assign mem_addr_wr = awr_q;
    assign mem_wdata   = wdat_q;

endmodule

// File: tb/tb_lobster_dbus_arbiter.sv
// Scoreboard bench for lobster_dbus_arbiter: SRAM responder
// model with programmable ready latency.
module tb_lobster_dbus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [35:0] fetch_addr = '0;
    logic        fetch_gnt;
    logic        load_req = 1'b0;
    logic [35:0] load_addr = '0;
    logic        load_gnt;
    logic        store_req = 1'b0;
    logic [35:0] store_addr = '0;
    logic [63:0] store_data = '0;
    logic        store_gnt;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        mem_ce;
    logic        mem_we;
    logic [35:0] mem_addr_rd;
    logic [35:0] mem_addr_wr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_rdy = 1'b0;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   gq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   lat_v = 1;
    int   acc_n = 0;
    int   ce_n;

    lobster_dbus_arbiter dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt),
        .load_req(load_req), .load_addr(load_addr),
        .load_gnt(load_gnt),
        .store_req(store_req), .store_addr(store_addr),
        .store_data(store_data), .store_gnt(store_gnt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_addr_rd(mem_addr_rd), .mem_addr_wr(mem_addr_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rdy(mem_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mdat(input logic [35:0] a);
        if (a == 36'hF800) return 64'h1122334455667788;
        return {a[31:0], ~a[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // SRAM: raises ready on the lat_v-th ACCESS cycle (0 = never).
    always @(negedge clk) begin
        if (!mem_ce) begin
            acc_n     = 0;
            mem_rdy   = 1'b0;
            mem_rdata = '0;
        end else begin
            acc_n++;
            mem_rdy   = (lat_v != 0) && (acc_n == lat_v);
            mem_rdata = mem_rdy ? mdat(mem_addr_rd) : 64'h0;
        end
    end

    always @(negedge clk) begin
        if (rst && rsp_valid) begin
            if (expq.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                mon_e = expq.pop_front();
                chk("rsp_id", rsp_id, mon_e.id);
                chk("rsp_data", rsp_data, mon_e.data);
                chk("rsp_err", rsp_err, mon_e.err);
            end
        end
    end

    task automatic push(input logic [1:0] id, input logic [63:0] d,
                        input logic e);
        exp_t x;
        x.id = id; x.data = d; x.err = e;
        expq.push_back(x);
    endtask

    // Drives until ns/nl/nf grants are seen and the bus drains.
    task automatic run(input int ns, input int nl, input int nf,
                       input int limit, output int cen);
        int k = 0;
        cen = 0;
        while ((ns + nl + nf > 0 || busy) && k < limit) begin
            @(negedge clk);
            k++;
            if (mem_ce) cen++;
            if (store_gnt) begin
                gq.push_back(3);
                chk("st_we", mem_we, 1);
                chk("st_wdata", mem_wdata, store_data);
                chk("st_addr", mem_addr_wr, store_addr);
                ns--;
                if (ns == 0) store_req = 1'b0;
            end
            if (load_gnt) begin
                gq.push_back(2);
                chk("ld_we", mem_we, 0);
                chk("ld_addr", mem_addr_rd, load_addr);
                nl--;
                if (nl == 0) load_req = 1'b0;
            end
            if (fetch_gnt) begin
                gq.push_back(1);
                chk("f_we", mem_we, 0);
                chk("f_addr", mem_addr_rd, fetch_addr);
                nf--;
                if (nf == 0) fetch_req = 1'b0;
            end
        end
        if (k >= limit) chk("run_timeout", 1, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ce", mem_ce, 0);
        chk("rst_rv", rsp_valid, 0);
        chk("rst_gnt", {fetch_gnt, load_gnt, store_gnt}, 0);
        rst = 1'b1;

        // single fetch, ready on first ACCESS cycle
        lat_v = 1;
        fetch_addr = 36'hF800;
        fetch_req = 1'b1;
        push(2'b01, 64'h1122334455667788, 1'b0);
        run(0, 0, 1, 20, ce_n);
        chk("f_ce_cycles", ce_n, 1);

        // all three at once
        gq.delete();
        store_addr = 36'h1_2345_6780;
        store_data = 64'hDEAD_BEEF_0BAD_F00D;
        load_addr  = 36'h0_0000_0440;
        fetch_addr = 36'h0_0000_0100;
        store_req = 1'b1; load_req = 1'b1; fetch_req = 1'b1;
        push(2'b11, 64'h0, 1'b0);
        push(2'b10, mdat(load_addr), 1'b0);
        push(2'b01, mdat(fetch_addr), 1'b0);
        run(1, 1, 1, 40, ce_n);
        chk("prio_n", gq.size(), 3);
        for (int i = 0; i < 3 && i < gq.size(); i++)
            chk("prio_order", gq[i], 3 - i);

        // starvation override
        gq.delete();
        fetch_addr = 36'h0_0000_0200;
        store_req = 1'b1; fetch_req = 1'b1;
        for (int i = 0; i < 4; i++) push(2'b11, 64'h0, 1'b0);
        push(2'b01, mdat(fetch_addr), 1'b0);
        push(2'b11, 64'h0, 1'b0);
        run(5, 0, 1, 60, ce_n);
        chk("starve_n", gq.size(), 6);
        for (int i = 0; i < 6 && i < gq.size(); i++)
            chk("starve_order", gq[i], (i == 4) ? 1 : 3);

        // load timeout
        lat_v = 0;
        load_addr = 36'h0_0000_0880;
        load_req = 1'b1;
        push(2'b10, 64'h0, 1'b1);
        run(0, 1, 0, 400, ce_n);
        chk("to_ce_cycles", ce_n, 255);

        // ready on the same edge the timeout would fire
        lat_v = 255;
        load_req = 1'b1;
        push(2'b10, mdat(load_addr), 1'b0);
        run(0, 1, 0, 400, ce_n);
        chk("race_ce_cycles", ce_n, 255);

        // async reset mid-access
        lat_v = 0;
        fetch_addr = 36'h0_0000_0300;
        fetch_req = 1'b1;
        begin
            int k = 0;
            while (!fetch_gnt && k < 10) begin
                @(negedge clk);
                k++;
            end
            chk("rstmid_gnt", fetch_gnt, 1);
        end
        fetch_req = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_ce", mem_ce, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_addr", mem_addr_rd, 0);
        repeat (2) @(negedge clk);
        chk("rstmid_rv", rsp_valid, 0);
        rst = 1'b1;
        lat_v = 1;
        fetch_req = 1'b1;
        push(2'b01, mdat(fetch_addr), 1'b0);
        run(0, 0, 1, 20, ce_n);
        chk("post_rst_ce", ce_n, 1);

        repeat (2) @(negedge clk);
        chk("exp_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
